// File: rtl/instruction_cache.sv
// Direct-mapped instruction cache with word-serial line refill from instruction memory.
// Defining ICACHE_STATS_EN adds hit_count/miss_count statistics outputs.
module instruction_cache #(
  parameter int unsigned LINES          = 16,
  parameter int unsigned WORDS_PER_LINE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instruction_address,
  input  logic        flush,
  output logic        hit,
  output logic [31:0] instruction,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_data
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int unsigned OFF_W = $clog2(WORDS_PER_LINE);
  localparam int unsigned IDX_W = $clog2(LINES);
  localparam int unsigned TAG_W = 32 - 2 - OFF_W - IDX_W;

  typedef enum logic {
    LOOKUP,
    REFILL
  } state_t;

  state_t state, state_next;

  logic [OFF_W-1:0] offset;
  logic [IDX_W-1:0] index;
  logic [TAG_W-1:0] tag;

  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [31:0]      data_mem [LINES][WORDS_PER_LINE];

  logic [TAG_W-1:0] fill_tag;
  logic [IDX_W-1:0] fill_index;
  logic [OFF_W-1:0] count;

  logic lookup_hit;
  logic start_fill;
  logic fill_we;
  logic fill_last;
  logic unused_byte_bits;

  assign offset = instruction_address[2 +: OFF_W];
  assign index  = instruction_address[2 + OFF_W +: IDX_W];
  assign tag    = instruction_address[31 -: TAG_W];
  assign unused_byte_bits = ^instruction_address[1:0];

  assign lookup_hit = valid[index] && (tag_mem[index] == tag);
  assign start_fill = (state == LOOKUP) && !lookup_hit && !flush;
  assign fill_we    = (state == REFILL) && mem_ready && !flush && !rst;
  assign fill_last  = (count == OFF_W'(WORDS_PER_LINE - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= LOOKUP;
    else     state <= state_next;
  end

  // Next-state logic; flush overrides everything, including a final refill write
  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = LOOKUP;
    end else begin
      case (state)
        LOOKUP:  if (!lookup_hit) state_next = REFILL;
        REFILL:  if (mem_ready && fill_last) state_next = LOOKUP;
        default: state_next = LOOKUP;
      endcase
    end
  end

  // Output logic: hit is a same-cycle lookup, refill address walks the latched line
  always_comb begin
    hit         = 1'b0;
    instruction = 32'h0;
    mem_req     = 1'b0;
    mem_addr    = 32'h0;
    if (state == LOOKUP && lookup_hit && !flush) begin
      hit         = 1'b1;
      instruction = data_mem[index][offset];
    end
    if (state == REFILL) begin
      mem_req  = 1'b1;
      mem_addr = {fill_tag, fill_index, count, 2'b00};
    end
  end

  // Valid bits, refill counter and latched line address
  always_ff @(posedge clk) begin
    if (rst) begin
      valid      <= '0;
      count      <= '0;
      fill_tag   <= '0;
      fill_index <= '0;
    end else if (flush) begin
      valid <= '0;
      count <= '0;
    end else if (start_fill) begin
      fill_tag      <= tag;
      fill_index    <= index;
      count         <= '0;
      valid[index]  <= 1'b0;
    end else if (fill_we) begin
      count <= count + OFF_W'(1);
      if (fill_last) valid[fill_index] <= 1'b1;
    end
  end

  // Tag and data arrays carry no reset; the valid bits guard them
  always_ff @(posedge clk) begin
    if (fill_we) begin
      data_mem[fill_index][count] <= mem_data;
      if (fill_last) tag_mem[fill_index] <= fill_tag;
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (hit)        hit_count  <= hit_count + 32'd1;
      if (start_fill) miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instruction_cache.sv
// Self-checking bench for instruction_cache: directed scenarios plus randomized
// fetch/flush/reset traffic compared every cycle against a line-level cache model.
module tb_instruction_cache;

  localparam int unsigned LINES = 16;
  localparam int unsigned WPL   = 4;
  localparam int unsigned LINE_BYTES = WPL * 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instruction_address = 32'h0;
  logic        flush = 1'b0;
  logic        hit;
  logic [31:0] instruction;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_data;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Instruction memory returns a word derived from its own address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  assign mem_data = mem_word(mem_addr);

  instruction_cache #(.LINES(LINES), .WORDS_PER_LINE(WPL)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .instruction_address (instruction_address),
    .flush               (flush),
    .hit                 (hit),
    .instruction         (instruction),
    .mem_req             (mem_req),
    .mem_addr            (mem_addr),
    .mem_ready           (mem_ready),
    .mem_data            (mem_data)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count           (hit_count),
    .miss_count          (miss_count)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: which line base address each set holds, and the line being fetched
  bit          model_ok = 1'b0;
  bit          m_refill = 1'b0;
  logic [31:0] m_base = 32'h0;
  int          m_done = 0;
  bit          m_valid [LINES];
  logic [31:0] m_line  [LINES];
  logic [31:0] m_hits = 32'h0;
  logic [31:0] m_misses = 32'h0;

  function automatic logic [31:0] line_of(input logic [31:0] a);
    return (a / LINE_BYTES) * LINE_BYTES;
  endfunction

  function automatic int idx_of(input logic [31:0] a);
    return int'((a / LINE_BYTES) % LINES);
  endfunction

  always @(negedge clk) begin
    bit          eh;
    logic [31:0] ei;
    logic [31:0] ea;
    int          ix;
    ix = idx_of(instruction_address);
    eh = !m_refill && m_valid[ix] && (m_line[ix] == line_of(instruction_address)) && !flush;
    ei = eh ? mem_word({instruction_address[31:2], 2'b00}) : 32'h0;
    ea = m_refill ? m_base + 32'(4 * m_done) : 32'h0;
    if (model_ok) begin
      chk("hit", 32'(hit), 32'(eh));
      chk("instruction", instruction, ei);
      chk("mem_req", 32'(mem_req), 32'(m_refill));
      chk("mem_addr", mem_addr, ea);
`ifdef ICACHE_STATS_EN
      chk("hit_count", hit_count, m_hits);
      chk("miss_count", miss_count, m_misses);
`endif
    end
    if (rst) begin
      model_ok = 1'b1;
      m_refill = 1'b0;
      m_done   = 0;
      m_hits   = 32'h0;
      m_misses = 32'h0;
      for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
    end else if (model_ok) begin
      if (flush) begin
        m_refill = 1'b0;
        for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
      end else if (!m_refill) begin
        if (eh) begin
          m_hits = m_hits + 32'd1;
        end else begin
          m_refill   = 1'b1;
          m_base     = line_of(instruction_address);
          m_done     = 0;
          m_valid[ix] = 1'b0;
          m_misses   = m_misses + 32'd1;
        end
      end else if (mem_ready) begin
        m_done++;
        if (m_done == WPL) begin
          m_valid[idx_of(m_base)] = 1'b1;
          m_line[idx_of(m_base)]  = m_base;
          m_refill = 1'b0;
        end
      end
    end
  end

  // One clock: apply inputs just after the rising edge, return after outputs are sampled
  task automatic cyc(input logic [31:0] a, input bit f, input bit r, input bit rs);
    @(posedge clk); #1;
    instruction_address = a;
    flush     = f;
    mem_ready = r;
    rst       = rs;
    @(negedge clk); #1;
  endtask

  initial begin
    logic [31:0] ra;
    cyc(32'h0, 1'b0, 1'b0, 1'b1);
    cyc(32'h0, 1'b0, 1'b0, 1'b1);
    chk("reset_hit", 32'(hit), 32'h0);
    chk("reset_req", 32'(mem_req), 32'h0);
    chk("reset_addr", mem_addr, 32'h0);
    chk("reset_instr", instruction, 32'h0);

    // Cold miss at 0x40, memory always ready
    cyc(32'h40, 1'b0, 1'b1, 1'b0);
    chk("cold_miss_hit", 32'(hit), 32'h0);
    for (int i = 0; i < 4; i++) begin
      cyc(32'h40, 1'b0, 1'b1, 1'b0);
      chk("cold_refill_addr", mem_addr, 32'(32'h40 + 4 * i));
      chk("cold_refill_req", 32'(mem_req), 32'h1);
    end
    cyc(32'h40, 1'b0, 1'b1, 1'b0);
    chk("cold_hit", 32'(hit), 32'h1);
    chk("cold_instr", instruction, 32'hDEAD_0040);

    // Remaining words of the line hit back-to-back; stray mem_ready ignored
    for (int k = 1; k < 4; k++) begin
      cyc(32'(32'h40 + 4 * k), 1'b0, 1'b1, 1'b0);
      chk("seq_hit", 32'(hit), 32'h1);
      chk("seq_req", 32'(mem_req), 32'h0);
      chk("seq_instr", instruction, 32'(32'hDEAD_0040 + 4 * k));
    end

    // Conflict at 0x140 evicts 0x40
    cyc(32'h140, 1'b0, 1'b1, 1'b0);
    chk("conflict_miss", 32'(hit), 32'h0);
    for (int i = 0; i < 4; i++) begin
      cyc(32'h140, 1'b0, 1'b1, 1'b0);
      chk("conflict_addr", mem_addr, 32'(32'h140 + 4 * i));
    end
    cyc(32'h140, 1'b0, 1'b0, 1'b0);
    chk("conflict_hit", 32'(hit), 32'h1);
    chk("conflict_instr", instruction, 32'hDEAD_0140);

    // 0x40 misses again; refill with mem_ready toggling
    cyc(32'h40, 1'b0, 1'b1, 1'b0);
    chk("evicted_miss", 32'(hit), 32'h0);
    for (int i = 0; i < 8; i++) begin
      cyc(32'h40, 1'b0, bit'(i % 2), 1'b0);
      chk("toggle_req", 32'(mem_req), 32'h1);
      chk("toggle_addr", mem_addr, 32'(32'h40 + 4 * (i / 2)));
    end
    cyc(32'h4C, 1'b0, 1'b0, 1'b0);
    chk("toggle_hit", 32'(hit), 32'h1);
    chk("toggle_instr", instruction, 32'hDEAD_004C);

    // Flush on the second refill cycle
    cyc(32'h80, 1'b0, 1'b1, 1'b0);
    cyc(32'h80, 1'b0, 1'b1, 1'b0);
    chk("flush_refill_addr", mem_addr, 32'h80);
    cyc(32'h80, 1'b1, 1'b1, 1'b0);
    chk("flush_cycle_hit", 32'(hit), 32'h0);
    cyc(32'h40, 1'b0, 1'b0, 1'b0);
    chk("after_flush_req", 32'(mem_req), 32'h0);
    chk("after_flush_hit", 32'(hit), 32'h0);
    // Refill of 0x40 completes even though the fetch address moves away
    cyc(32'h80, 1'b0, 1'b1, 1'b0);
    chk("latched_addr", mem_addr, 32'h40);
    for (int i = 0; i < 3; i++) cyc(32'h80, 1'b0, 1'b1, 1'b0);
    cyc(32'h48, 1'b0, 1'b0, 1'b0);
    chk("latched_hit", 32'(hit), 32'h1);
    chk("latched_instr", instruction, 32'hDEAD_0048);

    // Reset in the middle of a refill
    cyc(32'hC0, 1'b0, 1'b1, 1'b0);
    cyc(32'hC0, 1'b0, 1'b1, 1'b0);
    cyc(32'hC0, 1'b0, 1'b1, 1'b1);
    cyc(32'hC0, 1'b0, 1'b0, 1'b0);
    chk("rst_mid_req", 32'(mem_req), 32'h0);
    chk("rst_mid_hit", 32'(hit), 32'h0);
    chk("rst_mid_addr", mem_addr, 32'h0);
`ifdef ICACHE_STATS_EN
    chk("rst_hit_count", hit_count, 32'h0);
    chk("rst_miss_count", miss_count, 32'h0);
`endif

    // Random traffic over a small address window so lines are reused and conflict
    ra = 32'h0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 1) == 0)
        ra = 32'(($urandom_range(0, 1) << 8) | ($urandom_range(0, 3) << 4) | $urandom_range(0, 15));
      cyc(ra, $urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 299) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
